sqrt_result_check: RTL and testbench

//  Hardware result checker downstream of the sqrt32 core (chip_root).
//  - Watches the core's rdy and captures each x/y pair when rdy rises.
//  - Proves floor-sqrt correctness, y*y <= x < (y+1)*(y+1), using an iterative squarer.
//  - Keeps pass/fail counters and sticky error flags, so on-chip runs self-check without a bench.

---
 rtl/sqrt_pkg.sv | 20 ++
 rtl/sqrt_result_check_if.sv | 27 ++
 rtl/sqrt_result_check_sqr_iter.sv | 63 ++++++
 rtl/sqrt_result_check.sv | 147 ++++++++++++++
 tb/tb_sqrt_result_check.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_pkg.sv
// Shared constants and checker state encoding for the sqrt32 core, its
// result checker and the bench.
package sqrt_pkg;

  localparam int XW   = 32;
  localparam int YW   = 16;
  localparam int CNTW = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_CMP  = 2'd2
  } state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

endpackage

// File: rtl/sqrt_result_check_if.sv
// Result bus between the sqrt32 core side (master) and the checker (slave).
interface sqrt_result_check_if;
  import sqrt_pkg::*;

  logic            rdy;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            busy;
  logic            done;
  logic            pass;
  logic            err_big;
  logic            err_small;
  logic            overrun;
  logic [CNTW-1:0] pass_cnt;
  logic [CNTW-1:0] fail_cnt;

  modport master (
    output rdy, x, y,
    input  busy, done, pass, err_big, err_small, overrun, pass_cnt, fail_cnt
  );

  modport slave (
    input  rdy, x, y,
    output busy, done, pass, err_big, err_small, overrun, pass_cnt, fail_cnt
  );

endinterface

// File: rtl/sqrt_result_check_sqr_iter.sv
// Iterative shift-add squarer: one partial product per cycle, W cycles per square.
module sqr_iter
  import sqrt_pkg::*;
#(
  parameter int W = YW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  output logic         busy,
  output logic         last,
  output logic [2*W:0] acc
);

  localparam int IW = $clog2(W);
  localparam int AW = 2 * W + 1;

  logic [W-1:0]  a_q, a_d;
  logic [IW-1:0] i_q, i_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] acc_q, acc_d;

  assign last = busy_q && (i_q == IW'(W - 1));
  assign busy = busy_q;
  assign acc  = acc_q;

  always_comb begin
    a_d    = a_q;
    i_d    = i_q;
    busy_d = busy_q;
    acc_d  = acc_q;
    if (start) begin
      a_d    = a;
      i_d    = '0;
      busy_d = 1'b1;
      acc_d  = '0;
    end else if (busy_q) begin
      if (a_q[i_q]) begin
        acc_d = acc_q + (AW'(a_q) << i_q);
      end
      i_d = i_q + IW'(1);
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      i_q    <= '0;
      busy_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      a_q    <= a_d;
      i_q    <= i_d;
      busy_q <= busy_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/sqrt_result_check.sv
// On-chip checker for sqrt32 results: captures each x/y pair on rdy rising and
// proves y*y <= x < (y+1)^2, keeping counters and sticky error flags.
module sqrt_result_check
  import sqrt_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  sqrt_result_check_if.slave bus
);

  localparam int AW = 2 * YW + 1;

  state_e          state_q, state_d;
  logic            rdy_q;
  logic [XW-1:0]   x_r_q, x_r_d;
  logic [YW-1:0]   y_r_q, y_r_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            err_big_q, err_big_d;
  logic            err_small_q, err_small_d;
  logic            overrun_q, overrun_d;
  logic [CNTW-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNTW-1:0] fail_cnt_q, fail_cnt_d;

  logic            capture;
  logic            sq_start;
  logic            sq_busy;
  logic            sq_last;
  logic [AW-1:0]   sq_acc;
  logic [AW-1:0]   sq1;
  logic [AW-1:0]   x_ext;
  logic            sq_gt;
  logic            ok;

  assign capture  = bus.rdy & ~rdy_q;
  assign sq_start = (state_q == S_IDLE) && capture && !sq_busy;

  sqr_iter #(.W(YW)) u_sqr (
    .clk   (clk),
    .reset (reset),
    .start (sq_start),
    .a     (bus.y),
    .busy  (sq_busy),
    .last  (sq_last),
    .acc   (sq_acc)
  );

  // The extra top bit keeps (2^YW)^2 representable, so sq1 never wraps to 0.
  assign x_ext = {1'b0, x_r_q};
  assign sq1   = sq_acc + {{YW{1'b0}}, y_r_q, 1'b1};
  assign sq_gt = sq_acc > x_ext;
  assign ok    = !sq_gt && (sq1 > x_ext);

  always_comb begin
    state_d     = state_q;
    x_r_d       = x_r_q;
    y_r_d       = y_r_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_big_d   = err_big_q;
    err_small_d = err_small_q;
    overrun_d   = overrun_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;

    if (capture && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (sq_start) begin
          x_r_d   = bus.x;
          y_r_d   = bus.y;
          busy_d  = 1'b1;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (sq_last) begin
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        done_d = 1'b1;
        pass_d = ok;
        if (ok) begin
          pass_cnt_d = sat_inc(pass_cnt_q);
        end else begin
          fail_cnt_d = sat_inc(fail_cnt_q);
          if (sq_gt) begin
            err_big_d = 1'b1;
          end else begin
            err_small_d = 1'b1;
          end
        end
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      x_r_q       <= '0;
      y_r_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_big_q   <= 1'b0;
      err_small_q <= 1'b0;
      overrun_q   <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= bus.rdy;
      x_r_q       <= x_r_d;
      y_r_q       <= y_r_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_big_q   <= err_big_d;
      err_small_q <= err_small_d;
      overrun_q   <= overrun_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_big   = err_big_q;
  assign bus.err_small = err_small_q;
  assign bus.overrun   = overrun_q;
  assign bus.pass_cnt  = pass_cnt_q;
  assign bus.fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_sqrt_result_check.sv
// Bench for sqrt_result_check: a cycle-level behavioural model checked against
// every output each cycle, plus directed literal expectations and random pairs.
module tb_sqrt_result_check;
  import sqrt_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sqrt_result_check_if bus();

  sqrt_result_check dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic longint isqrt(input longint v);
    longint r = 0;
    for (int b = YW - 1; b >= 0; b--) begin
      longint t = r | (longint'(1) << b);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction

  // Behavioural model: a check accepted on a rising rdy finishes 17 edges later;
  // any rising rdy while a check is outstanding is an overrun.
  bit     m_valid = 0;
  bit     m_prev_rdy, m_cap;
  int     m_left;
  longint m_x, m_y, m_sq;
  bit     m_busy, m_done, m_pass, m_big, m_small, m_over, m_ok;
  int     m_pcnt, m_fcnt;

  always @(posedge clk) begin
    if (reset) begin
      m_prev_rdy = 0; m_left = 0; m_done = 0; m_pass = 0;
      m_big = 0; m_small = 0; m_over = 0; m_pcnt = 0; m_fcnt = 0;
    end else begin
      m_cap  = bus.rdy && !m_prev_rdy;
      m_done = 0;
      if (m_left > 0) begin
        if (m_cap) m_over = 1;
        m_left--;
        if (m_left == 0) begin
          m_sq   = m_y * m_y;
          m_ok   = (m_sq <= m_x) && ((m_y + 1) * (m_y + 1) > m_x);
          m_done = 1;
          m_pass = m_ok;
          if (m_ok) begin
            if (m_pcnt < 65535) m_pcnt++;
          end else begin
            if (m_fcnt < 65535) m_fcnt++;
            if (m_sq > m_x) m_big = 1;
            else m_small = 1;
          end
        end
      end else if (m_cap) begin
        m_x    = longint'(bus.x);
        m_y    = longint'(bus.y);
        m_left = 17;
      end
      m_prev_rdy = bus.rdy;
    end
    m_busy  = (m_left > 0);
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("busy",      bus.busy,      m_busy);
      checkOutput("done",      bus.done,      m_done);
      checkOutput("pass",      bus.pass,      m_pass);
      checkOutput("err_big",   bus.err_big,   m_big);
      checkOutput("err_small", bus.err_small, m_small);
      checkOutput("overrun",   bus.overrun,   m_over);
      checkOutput("pass_cnt",  bus.pass_cnt,  m_pcnt);
      checkOutput("fail_cnt",  bus.fail_cnt,  m_fcnt);
    end
  end

  task automatic doReset();
    @(negedge clk);
    reset   = 1'b1;
    bus.rdy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One rdy pulse with the given pair; returns cycles until done (0 = timed out).
  task automatic applyStimulus(input logic [XW-1:0] xv, input logic [YW-1:0] yv, output int lat);
    @(negedge clk);
    bus.x   = xv;
    bus.y   = yv;
    bus.rdy = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) bus.rdy = 1'b0;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int dones;
    int bad_lat;
    longint rx, ry;

    reset = 1'b1;
    bus.rdy = 1'b0;
    bus.x = '0;
    bus.y = '0;

    // 1: reset state and first check
    doReset();
    checkOutput("rst_flags", {bus.busy, bus.done, bus.pass, bus.err_big, bus.err_small, bus.overrun}, 0);
    checkOutput("rst_pass_cnt", bus.pass_cnt, 0);
    checkOutput("rst_fail_cnt", bus.fail_cnt, 0);
    applyStimulus(32'd1, 16'd1, lat);
    checkOutput("t1_latency", lat, 18);
    checkOutput("t1_pass", bus.pass, 1);
    checkOutput("t1_pass_cnt", bus.pass_cnt, 1);

    // 2: two passing pairs
    doReset();
    applyStimulus(32'd3, 16'd1, lat);
    checkOutput("t2a_pass", bus.pass, 1);
    applyStimulus(32'd4, 16'd2, lat);
    checkOutput("t2b_pass", bus.pass, 1);
    checkOutput("t2_pass_cnt", bus.pass_cnt, 2);
    checkOutput("t2_errs", {bus.err_big, bus.err_small}, 0);

    // 3: root too small, then too big
    doReset();
    applyStimulus(32'd4, 16'd1, lat);
    checkOutput("t3a_pass", bus.pass, 0);
    checkOutput("t3a_err_small", bus.err_small, 1);
    checkOutput("t3a_err_big", bus.err_big, 0);
    checkOutput("t3a_fail_cnt", bus.fail_cnt, 1);
    applyStimulus(32'd3, 16'd2, lat);
    checkOutput("t3b_pass", bus.pass, 0);
    checkOutput("t3b_err_big", bus.err_big, 1);
    checkOutput("t3b_fail_cnt", bus.fail_cnt, 2);

    // 4: width boundary
    doReset();
    applyStimulus(32'hFFFF_FFFF, 16'hFFFF, lat);
    checkOutput("t4a_pass", bus.pass, 1);
    checkOutput("t4a_err_small", bus.err_small, 0);
    applyStimulus(32'hFFFE_0000, 16'hFFFF, lat);
    checkOutput("t4b_pass", bus.pass, 0);
    checkOutput("t4b_err_big", bus.err_big, 1);

    // 5a: second rdy pulse 5 cycles into a check
    doReset();
    @(negedge clk);
    bus.x = 32'd1; bus.y = 16'd1; bus.rdy = 1'b1;
    dones = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) bus.rdy = 1'b0;
      if (n == 5) begin bus.x = 32'd4; bus.y = 16'd1; bus.rdy = 1'b1; end
      if (n == 6) bus.rdy = 1'b0;
      if (bus.done) dones++;
    end
    checkOutput("t5a_dones", dones, 1);
    checkOutput("t5a_overrun", bus.overrun, 1);
    checkOutput("t5a_pass", bus.pass, 1);
    checkOutput("t5a_fail_cnt", bus.fail_cnt, 0);

    // 5b: rdy held high is checked once
    @(negedge clk);
    bus.x = 32'd16; bus.y = 16'd4; bus.rdy = 1'b1;
    dones = 0;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      if (n == 100) bus.rdy = 1'b0;
      if (bus.done) dones++;
    end
    checkOutput("t5b_dones", dones, 1);
    checkOutput("t5b_pass_cnt", bus.pass_cnt, 2);

    // 6a: reset in the middle of the multiply
    doReset();
    @(negedge clk);
    bus.x = 32'd9; bus.y = 16'd3; bus.rdy = 1'b1;
    dones = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) bus.rdy = 1'b0;
      if (n == 8) reset = 1'b1;
      if (n == 10) reset = 1'b0;
      if (bus.done) dones++;
    end
    checkOutput("t6a_dones", dones, 0);
    checkOutput("t6a_counts", {bus.pass_cnt, bus.fail_cnt}, 0);
    checkOutput("t6a_flags", {bus.busy, bus.err_big, bus.err_small, bus.overrun}, 0);

    // 6b: random radicands with reference floor-sqrt roots
    bad_lat = 0;
    for (int k = 0; k < 200; k++) begin
      rx = longint'($urandom);
      ry = isqrt(rx);
      applyStimulus(rx[XW-1:0], ry[YW-1:0], lat);
      if (lat != 18) bad_lat++;
    end
    checkOutput("t6b_latency_misses", bad_lat, 0);
    checkOutput("t6b_pass_cnt", bus.pass_cnt, 200);
    checkOutput("t6b_fail_cnt", bus.fail_cnt, 0);

    // 6c: random off-by-one roots, judged by the model alone
    for (int k = 0; k < 20; k++) begin
      rx = longint'($urandom);
      ry = isqrt(rx);
      if ($urandom_range(0, 1) == 1 && ry > 0) ry = ry - 1;
      else if (ry < 65535) ry = ry + 1;
      else ry = ry - 1;
      applyStimulus(rx[XW-1:0], ry[YW-1:0], lat);
    end
    checkOutput("t6c_fail_cnt", bus.fail_cnt, 20);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
